// File: rtl/sdhci_pkg.sv
// Shared types and helpers for the SDHCI buffer data port.
// Holds the buffer state enum, the block-length width and the byte-to-word rounding.
package sdhci_pkg;

  typedef enum logic [1:0] {
    BUF_IDLE  = 2'd0,
    BUF_WRITE = 2'd1,
    BUF_READ  = 2'd2
  } sdhci_buf_state_e;

  localparam int SdhciBlkWordsW = 10;

  // Round a byte count up to whole 32-bit words; 4093..4095 bytes wrap to 0 (invalid anyway).
  function automatic logic [SdhciBlkWordsW-1:0] sdhci_buf_blk_words(input logic [11:0] bs);
    return SdhciBlkWordsW'(({1'b0, bs} + 13'd3) >> 2);
  endfunction

endpackage

// File: rtl/sdhci_buffer_fifo.sv
// Synchronous first-word-fall-through FIFO with flush, fill/free counts and flags.
// Head word reads as 0 while the FIFO is empty.
module sdhci_buffer_fifo #(
  parameter int DataWidth  = 32,
  parameter int DepthWords = 128
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic                          push_i,
  input  logic [DataWidth-1:0]          wdata_i,
  input  logic                          pop_i,
  output logic [DataWidth-1:0]          rdata_o,
  output logic [$clog2(DepthWords):0]   fill_o,
  output logic [$clog2(DepthWords):0]   free_o,
  output logic                          full_o,
  output logic                          empty_o
);
  localparam int AW = $clog2(DepthWords);
  localparam int CW = AW + 1;

  logic [DataWidth-1:0] r_mem [DepthWords];
  logic [AW-1:0]        r_wptr, r_rptr;
  logic [CW-1:0]        r_fill;
  logic                 w_push, w_pop;

  assign full_o  = (r_fill == CW'(DepthWords));
  assign empty_o = (r_fill == '0);
  assign fill_o  = r_fill;
  assign free_o  = CW'(DepthWords) - r_fill;
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;
  assign rdata_o = empty_o ? '0 : r_mem[r_rptr];

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fill <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_fill <= r_fill + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/sdhci_buffer_port.sv
// Block-granular buffer behind the SDHCI Buffer Data Port: state machine, enables, interrupt pulses.
// Optional sticky host access error is built only when SDHCI_BUFFER_ERR_EN is defined.
module sdhci_buffer_port
  import sdhci_pkg::*;
#(
  parameter int DataWidth  = 32,
  parameter int DepthWords = 128
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic                 dir_i,
  input  logic [11:0]          block_size_i,
  input  logic [DataWidth-1:0] host_wdata_i,
  input  logic                 host_we_i,
  input  logic                 host_re_i,
  output logic [DataWidth-1:0] host_rdata_o,
  input  logic [DataWidth-1:0] card_wdata_i,
  input  logic                 card_wvalid_i,
  output logic                 card_wready_o,
  output logic [DataWidth-1:0] card_rdata_o,
  output logic                 card_rvalid_o,
  input  logic                 card_rready_i,
  output logic                 buf_wr_en_o,
  output logic                 buf_rd_en_o,
  output logic                 buf_wr_rdy_o,
  output logic                 buf_rd_rdy_o,
  output logic                 err_o
);
  localparam int CW = $clog2(DepthWords) + 1;
  localparam int TW = CW + SdhciBlkWordsW;

  sdhci_buf_state_e          r_state;
  logic [SdhciBlkWordsW-1:0] r_blk_words, r_host_cnt;
  logic                      r_blk_ok, r_wr_thr, r_rd_thr;
  logic                      r_wr_en, r_rd_en, r_wr_rdy, r_rd_rdy;

  logic                      w_flush, w_push, w_pop, w_full, w_empty;
  logic                      w_host_push, w_host_pop, w_card_push, w_card_pop, w_last;
  logic [CW-1:0]             w_fill, w_free, w_fill_nxt, w_free_nxt;
  logic [DataWidth-1:0]      w_rdata, w_wdata;
  logic [SdhciBlkWordsW-1:0] w_start_blk;
  logic                      w_rd_hit, w_wr_hit, w_rd_hit_nxt, w_wr_hit_nxt;

  assign w_flush     = start_i | abort_i;
  assign w_host_push = r_wr_en & host_we_i & ~w_full;
  assign w_host_pop  = r_rd_en & host_re_i & ~w_empty;
  assign w_card_push = (r_state == BUF_READ)  & card_wvalid_i & ~w_full;
  assign w_card_pop  = (r_state == BUF_WRITE) & card_rready_i & ~w_empty;
  assign w_push      = w_host_push | w_card_push;
  assign w_pop       = w_host_pop  | w_card_pop;
  assign w_wdata     = (r_state == BUF_WRITE) ? host_wdata_i : card_wdata_i;
  assign w_last      = (w_host_push | w_host_pop) && (r_host_cnt + 1'b1 == r_blk_words);
  assign w_start_blk = sdhci_buf_blk_words(block_size_i);

  sdhci_buffer_fifo #(.DataWidth(DataWidth), .DepthWords(DepthWords)) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .flush_i(w_flush),
    .push_i (w_push),
    .wdata_i(w_wdata),
    .pop_i  (w_pop),
    .rdata_o(w_rdata),
    .fill_o (w_fill),
    .free_o (w_free),
    .full_o (w_full),
    .empty_o(w_empty)
  );

  // On the edge that closes a block the threshold is taken from the post-edge count,
  // so a stale pre-pop/pre-push level can never re-arm an incomplete block.
  assign w_fill_nxt   = w_fill + CW'(w_push) - CW'(w_pop);
  assign w_free_nxt   = CW'(DepthWords) - w_fill_nxt;
  assign w_rd_hit     = TW'(w_fill)     >= TW'(r_blk_words);
  assign w_wr_hit     = TW'(w_free)     >= TW'(r_blk_words);
  assign w_rd_hit_nxt = TW'(w_fill_nxt) >= TW'(r_blk_words);
  assign w_wr_hit_nxt = TW'(w_free_nxt) >= TW'(r_blk_words);

  always_ff @(posedge clk_i) begin
    if (!rst_ni || w_flush) begin
      r_state    <= BUF_IDLE;
      r_host_cnt <= '0;
      r_wr_thr   <= 1'b0;
      r_rd_thr   <= 1'b0;
      r_wr_en    <= 1'b0;
      r_rd_en    <= 1'b0;
      r_wr_rdy   <= 1'b0;
      r_rd_rdy   <= 1'b0;
      if (!rst_ni) begin
        r_blk_words <= '0;
        r_blk_ok    <= 1'b0;
      end else if (!abort_i) begin
        r_state     <= dir_i ? BUF_READ : BUF_WRITE;
        r_blk_words <= w_start_blk;
        r_blk_ok    <= (w_start_blk != '0) && (TW'(w_start_blk) <= TW'(DepthWords));
      end
    end else begin
      r_wr_rdy <= 1'b0;
      r_rd_rdy <= 1'b0;
      r_rd_thr <= (r_state == BUF_READ)  && r_blk_ok && (w_last ? w_rd_hit_nxt : w_rd_hit);
      r_wr_thr <= (r_state == BUF_WRITE) && r_blk_ok && (w_last ? w_wr_hit_nxt : w_wr_hit);
      if (w_host_push || w_host_pop)
        r_host_cnt <= w_last ? '0 : r_host_cnt + 1'b1;
      if (w_last) begin
        r_wr_en <= 1'b0;
        r_rd_en <= 1'b0;
      end else begin
        if (!r_rd_en && r_rd_thr) begin
          r_rd_en  <= 1'b1;
          r_rd_rdy <= 1'b1;
        end
        if (!r_wr_en && r_wr_thr) begin
          r_wr_en  <= 1'b1;
          r_wr_rdy <= 1'b1;
        end
      end
    end
  end

  assign host_rdata_o  = w_rdata;
  assign card_rdata_o  = w_rdata;
  assign card_wready_o = (r_state == BUF_READ)  & ~w_full;
  assign card_rvalid_o = (r_state == BUF_WRITE) & ~w_empty;
  assign buf_wr_en_o   = r_wr_en;
  assign buf_rd_en_o   = r_rd_en;
  assign buf_wr_rdy_o  = r_wr_rdy;
  assign buf_rd_rdy_o  = r_rd_rdy;

`ifdef SDHCI_BUFFER_ERR_EN
  logic r_err;
  always_ff @(posedge clk_i) begin
    if (!rst_ni || w_flush)
      r_err <= 1'b0;
    else if ((host_re_i && !r_rd_en) || (host_we_i && !r_wr_en))
      r_err <= 1'b1;
  end
  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: doc/sdhci_buffer_port.md
# sdhci_buffer_port

Block-granular data buffer behind the SDHCI Buffer Data Port register (offset 0x20). Sits directly downstream of the OBI register block: the top level maps the data-port write/read strobes and write data from `reg2hw` onto this block, and its read data and status flags back onto `hw2reg`. On the other side, the block exchanges 32-bit words with the SD data-line engine over valid/ready streams. It generates the Buffer Write Enable and Buffer Read Enable status bits, plus the matching interrupt pulses.

## Interface
- `DataWidth`, 32: word width. Only 32 is supported.
- `DepthWords`, 128: FIFO depth in words (512 B). Must be a power of two and at least 2.
- `clk_i`  in  1  system clock
- `rst_ni`  in  1  reset; one clock, reset is synchronous and active-low
- `start_i`  in  1  one-cycle pulse; flushes the FIFO and starts a transfer in direction `dir_i`
- `abort_i`  in  1  one-cycle pulse; flushes the FIFO and returns to IDLE
- `dir_i`  in  1  sampled on `start_i`; 1 = card→host (READ), 0 = host→card (WRITE)
- `block_size_i`  in  12  block size in bytes; sampled on `start_i`
- `host_wdata_i`  in  32  data-port write data
- `host_we_i`  in  1  data-port write strobe (register qe)
- `host_re_i`  in  1  data-port read strobe (register re)
- `host_rdata_o`  out  32  data-port read data (FIFO head)
- `card_wdata_i`  in  32  card→buffer word
- `card_wvalid_i`  in  1  card→buffer valid
- `card_wready_o`  out  1  card→buffer ready
- `card_rdata_o`  out  32  buffer→card word
- `card_rvalid_o`  out  1  buffer→card valid
- `card_rready_i`  in  1  buffer→card ready
- `buf_wr_en_o`  out  1  Buffer Write Enable status
- `buf_rd_en_o`  out  1  Buffer Read Enable status
- `buf_wr_rdy_o`  out  1  one-cycle Buffer Write Ready interrupt pulse
- `buf_rd_rdy_o`  out  1  one-cycle Buffer Read Ready interrupt pulse
- `err_o`  out  1  sticky host access error (see Configuration)

## Operation
- Block length: `blk_words = (block_size_i + 3) >> 2`, a 10-bit value latched on `start_i`. If `blk_words` is 0 or greater than `DepthWords`, both enables stay 0 for the whole transfer.
- The state machine has three states: IDLE, WRITE and READ.
  - `start_i` moves to WRITE or READ according to `dir_i` from any state.
  - `abort_i` moves to IDLE.
  - If `start_i` and `abort_i` are high in the same cycle, `abort_i` wins.
  - Both `start_i` and `abort_i` empty the FIFO and clear `host_cnt` and both enables in that same cycle.
- READ state:
  - The card side pushes into the FIFO. `card_wready_o` = !full.
  - If `buf_rd_en_o` is 0 and `fill >= blk_words`, set `buf_rd_en_o` and pulse `buf_rd_rdy_o`.
  - Each `host_re_i` while `buf_rd_en_o` is 1 pops one word and increments `host_cnt`.
  - On the `blk_words`-th pop, clear `buf_rd_en_o` and reset `host_cnt` to 0.
- WRITE state:
  - If `buf_wr_en_o` is 0 and `free >= blk_words`, set `buf_wr_en_o` and pulse `buf_wr_rdy_o`.
  - Each `host_we_i` while `buf_wr_en_o` is 1 pushes `host_wdata_i`.
  - The `blk_words`-th push clears `buf_wr_en_o`.
  - The card side pops: `card_rvalid_o` = !empty.
- IDLE state: `card_wready_o`, `card_rvalid_o` and both enables are 0. Host strobes are ignored.
- Host strobes that arrive while the relevant enable is 0 are ignored; they never push or pop.
- The FIFO handles a push and a pop in the same cycle; `fill` is unchanged.

## Timing
- Reset values: all outputs are 0, state is IDLE, the FIFO is empty, `host_cnt` = 0 and `err_o` = 0. `host_rdata_o` is 0 while the FIFO is empty.
- The FIFO is first-word-fall-through: `host_rdata_o` and `card_rdata_o` show the head word combinationally. A pop takes effect at the clock edge.
- A push becomes visible in `fill` one cycle later. An enable rises in the cycle after its threshold condition is registered, so it rises 2 cycles after the last qualifying push or pop.
- After an enable clears on the last word of a block, it stays 0 for at least one cycle before it can be set again. Each re-arm produces a new interrupt pulse.
- The enable flags, the interrupt pulses, `err_o` and `card_*` ready/valid are all driven from registers or from FIFO flags. There are no combinational paths from inputs to these outputs.

## Configuration
- `SDHCI_BUFFER_ERR_EN` defined:
  - `err_o` is set on a `host_re_i` while `buf_rd_en_o` is 0, or on a `host_we_i` while `buf_wr_en_o` is 0.
  - `err_o` is cleared by `start_i`, `abort_i` or reset.
- `SDHCI_BUFFER_ERR_EN` undefined: `err_o` is tied to 0 and no error logic is generated.

## Structure
- `sdhci_pkg` holds:
  - the `sdhci_buf_state_e` enum (IDLE/WRITE/READ);
  - the `SdhciBlkWordsW` = 10 constant;
  - the `sdhci_buf_blk_words()` function for the rounding.
- Sub-module `sdhci_buffer_fifo`:
  - synchronous first-word-fall-through FIFO with `flush_i`;
  - outputs `fill`/`free` counts and `full`/`empty` flags;
  - depth `DepthWords`.
- The top module contains the state machine, the enable/pulse logic and the error logic.

## Test plan
- READ with `block_size_i`=512 and the card pushing 128 words back-to-back:
  - `buf_rd_en_o` and `buf_rd_rdy_o` rise 2 cycles after the 128th push;
  - 128 host reads return data in push order;
  - the enable clears on the 128th read.
- WRITE with `block_size_i`=6:
  - `buf_wr_en_o` rises 2 cycles after start;
  - 2 host writes clear it;
  - it re-arms 1 cycle later, with `card_rdata_o` presenting the first written word.
- Simultaneous card push and host pop in READ with 2 blocks of 4 words each:
  - `fill` stays constant on overlapping cycles;
  - exactly 2 `buf_rd_rdy_o` pulses occur.
- `abort_i` after 3 of 4 words have been read mid-block:
  - the FIFO empties, the enables go to 0 and the state is IDLE;
  - a subsequent `start_i` with READ behaves like a fresh transfer.
- `block_size_i`=0 and `block_size_i`=2049: the enables never assert; with `SDHCI_BUFFER_ERR_EN`, a host read sets `err_o`=1.
- Synchronous reset asserted mid-WRITE: on the next edge all outputs are 0 and the FIFO is empty.
